// File: rtl/mult_seq_pkg.sv
// Shared definitions for the digit-serial multiplier: FSM state encoding and
// the partial-product index width helper.
package mult_seq_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      IDLE  = 3'd0,
      CALC  = 3'd1,
      DRAIN = 3'd2,
      DONE  = 3'd3,
      ERR   = 3'd4
   } state_t;

   // Width of the partial-product index: clog2((w/d)^2), never below 1.
   function automatic int calc_iw(input int w, input int d);
      int npp;
      npp = (w / d) * (w / d);
      return (npp < 2) ? 1 : $clog2(npp);
   endfunction

endpackage

// File: rtl/mult_seq_digit_mul.sv
// Combinational D x D unsigned digit multiplier producing a 2D-bit product.
module mult_seq_digit_mul #(
   parameter int D = 4
) (
   input  logic [D-1:0]   x,
   input  logic [D-1:0]   y,
   output logic [2*D-1:0] p
);

   assign p = {{D{1'b0}}, x} * {{D{1'b0}}, y};

endmodule

// File: rtl/mult_seq_digit.sv
// Sequential W x W unsigned multiplier, one D x D digit product per cycle.
// Define MULT_SEQ_PIPE_EN to register the partial product before accumulation.
module mult_seq_digit
   import mult_seq_pkg::*;
#(
   parameter  int W  = 8,
   parameter  int D  = 4,
   localparam int IW = calc_iw(W, D)
) (
   input  logic               clk,
   input  logic               reset_a,
   input  logic               start,
   input  logic [W-1:0]       a,
   input  logic [W-1:0]       b,
   output logic [2*W-1:0]     product,
   output logic               done,
   output logic               busy,
   output logic               err,
   output logic [STATE_W-1:0] state_out,
   output logic [IW-1:0]      pp_idx
);

   localparam int NCH = W / D;
   localparam int NPP = NCH * NCH;

   state_t         state;
   logic [W-1:0]   a_q;
   logic [W-1:0]   b_q;
   logic [2*W-1:0] acc;

   logic [D-1:0]   a_dig;
   logic [D-1:0]   b_dig;
   logic [2*D-1:0] pp_raw;
   logic [2*W-1:0] pp_shift;
   logic [2*W-1:0] addend;

   assign state_out = state;

   // k = pp_idx selects digit i = k mod NCH of a and digit j = k div NCH of b.
   always_comb begin
      int idx_i;
      int idx_j;
      idx_i    = int'(pp_idx) % NCH;
      idx_j    = int'(pp_idx) / NCH;
      a_dig    = D'(a_q >> (idx_i * D));
      b_dig    = D'(b_q >> (idx_j * D));
      pp_shift = (2*W)'(pp_raw) << ((idx_i + idx_j) * D);
   end

   mult_seq_digit_mul #(.D(D)) u_mul (
      .x (a_dig),
      .y (b_dig),
      .p (pp_raw)
   );

`ifdef MULT_SEQ_PIPE_EN
   logic [2*W-1:0] pp_q;
   logic           pp_vld;

   // The first CALC cycle has nothing in the pipeline register yet.
   assign addend = pp_vld ? pp_q : '0;
`else
   assign addend = pp_shift;
`endif

   // NOTE: all state uses non-blocking assignments so every register samples
   // the pre-edge values of its neighbours, independent of statement order.
   always_ff @(posedge clk or negedge reset_a) begin
      if (!reset_a) begin
         state   <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc     <= '0;
         product <= '0;
         pp_idx  <= '0;
         done    <= 1'b0;
         busy    <= 1'b0;
         err     <= 1'b0;
`ifdef MULT_SEQ_PIPE_EN
         pp_q    <= '0;
         pp_vld  <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE, ERR: begin
               if (start) begin
                  a_q    <= a;
                  b_q    <= b;
                  acc    <= '0;
                  pp_idx <= '0;
                  busy   <= 1'b1;
                  err    <= 1'b0;
                  state  <= CALC;
`ifdef MULT_SEQ_PIPE_EN
                  pp_vld <= 1'b0;
`endif
               end else if (state == DONE) begin
                  state <= IDLE;
               end
            end

            CALC: begin
               if (start) begin
                  busy  <= 1'b0;
                  err   <= 1'b1;
                  state <= ERR;
               end else begin
                  acc <= acc + addend;
`ifdef MULT_SEQ_PIPE_EN
                  pp_q   <= pp_shift;
                  pp_vld <= 1'b1;
`endif
                  if (pp_idx == IW'(NPP - 1)) begin
`ifdef MULT_SEQ_PIPE_EN
                     state <= DRAIN;
`else
                     product <= acc + addend;
                     done    <= 1'b1;
                     busy    <= 1'b0;
                     state   <= DONE;
`endif
                  end else begin
                     pp_idx <= pp_idx + IW'(1);
                  end
               end
            end

`ifdef MULT_SEQ_PIPE_EN
            DRAIN: begin
               if (start) begin
                  busy  <= 1'b0;
                  err   <= 1'b1;
                  state <= ERR;
               end else begin
                  acc     <= acc + pp_q;
                  product <= acc + pp_q;
                  pp_vld  <= 1'b0;
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  state   <= DONE;
               end
            end
`endif

            default: begin
               busy  <= 1'b0;
               err   <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_seq_digit.sv
// Scoreboard bench for mult_seq_digit: W=8 instance for the main sequences and
// a W=16 instance for the wide-operand case.
module tb_mult_seq_digit;

`ifdef MULT_SEQ_PIPE_EN
   localparam int EXTRA = 1;
`else
   localparam int EXTRA = 0;
`endif
   localparam int NPP8  = 4;
   localparam int NPP16 = 16;
   localparam int LAT8  = NPP8 + 1 + EXTRA;
   localparam int LAT16 = NPP16 + 1 + EXTRA;

   logic        clk;
   logic        reset_a;
   logic        start;
   logic [7:0]  a;
   logic [7:0]  b;
   logic [15:0] product;
   logic        done;
   logic        busy;
   logic        err;
   logic [2:0]  state_out;
   logic [1:0]  pp_idx;

   logic        start16;
   logic [15:0] a16;
   logic [15:0] b16;
   logic [31:0] product16;
   logic        done16;
   logic        busy16;
   logic        err16;
   logic [2:0]  state16;
   logic [3:0]  pp_idx16;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          done_cnt = 0;
   logic        done_prev = 1'b0;
   logic [15:0] sb[$];

   mult_seq_digit #(.W(8), .D(4)) dut (
      .clk       (clk),
      .reset_a   (reset_a),
      .start     (start),
      .a         (a),
      .b         (b),
      .product   (product),
      .done      (done),
      .busy      (busy),
      .err       (err),
      .state_out (state_out),
      .pp_idx    (pp_idx)
   );

   mult_seq_digit #(.W(16), .D(4)) dut16 (
      .clk       (clk),
      .reset_a   (reset_a),
      .start     (start16),
      .a         (a16),
      .b         (b16),
      .product   (product16),
      .done      (done16),
      .busy      (busy16),
      .err       (err16),
      .state_out (state16),
      .pp_idx    (pp_idx16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Output monitor: every done pulse retires the oldest expected product.
   always @(negedge clk) begin
      if (reset_a && done) begin
         done_cnt++;
         check("done_single", done_prev, 1'b0);
         if (sb.size() == 0) check("done_unexpected", 1, 0);
         else check("product", product, sb.pop_front());
      end
      done_prev = done & reset_a;
   end

   task automatic run_mul(input logic [7:0] av, input logic [7:0] bv, input bit b2b,
                          output int lat);
      logic [15:0] e;
      if (!b2b) @(negedge clk);
      a     = av;
      b     = bv;
      start = 1'b1;
      e     = av * bv;
      sb.push_back(e);
      @(posedge clk);
      #1 start = 1'b0;
      lat = 1;
      while (lat < 100) begin
         @(negedge clk);
         if (lat == 1) begin
            check("state_calc", state_out, 3'd1);
            check("err_clear", err, 1'b0);
         end
         if (done) break;
         check("busy", busy, 1'b1);
         if (lat - 1 < NPP8) check("pp_idx", pp_idx, lat - 1);
         @(posedge clk);
         lat++;
      end
      if (lat >= 100) check("done_timeout", 0, 1);
   endtask

   initial begin
      int lat;
      int cnt0;
      int busy_cnt;
      reset_a = 1'b0;
      start   = 1'b0;
      a       = '0;
      b       = '0;
      start16 = 1'b0;
      a16     = '0;
      b16     = '0;
      repeat (2) @(negedge clk);
      check("rst_state", state_out, 3'd0);
      check("rst_product", product, 16'h0);
      check("rst_done", done, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_pp_idx", pp_idx, 2'd0);
      reset_a = 1'b1;

      run_mul(8'h12, 8'h34, 1'b0, lat);
      check("lat_12x34", lat, LAT8);
      run_mul(8'hFF, 8'hFF, 1'b0, lat);
      check("lat_ffxff", lat, LAT8);
      run_mul(8'h00, 8'hAB, 1'b0, lat);
      check("lat_00xab", lat, LAT8);
      run_mul(8'h0F, 8'h10, 1'b1, lat);
      check("lat_b2b", lat, LAT8);

      // Abort during the second CALC cycle; product must keep 0x00F0.
      @(negedge clk);
      a = 8'h77;
      b = 8'h77;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (2) @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      check("err_flag", err, 1'b1);
      check("err_busy", busy, 1'b0);
      check("err_state", state_out, 3'd4);
      check("err_product", product, 16'h00F0);
      check("err_done", done, 1'b0);
      repeat (2) @(negedge clk);
      check("err_hold", state_out, 3'd4);
      run_mul(8'h03, 8'h05, 1'b0, lat);
      check("lat_restart", lat, LAT8);

      // Asynchronous reset in the middle of CALC.
      @(negedge clk);
      a = 8'h55;
      b = 8'h66;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (2) @(negedge clk);
      #3 reset_a = 1'b0;
      #1;
      check("arst_state", state_out, 3'd0);
      check("arst_product", product, 16'h0);
      check("arst_busy", busy, 1'b0);
      @(negedge clk);
      reset_a = 1'b1;
      cnt0 = done_cnt;
      repeat (12) @(negedge clk);
      check("no_done_after_reset", done_cnt, cnt0);
      check("idle_after_reset", state_out, 3'd0);

      // Wide instance.
      @(negedge clk);
      a16 = 16'hFFFF;
      b16 = 16'h0002;
      start16 = 1'b1;
      @(posedge clk);
      #1 start16 = 1'b0;
      lat = 1;
      busy_cnt = 0;
      while (lat < 100) begin
         @(negedge clk);
         if (done16) break;
         if (busy16) busy_cnt++;
         @(posedge clk);
         lat++;
      end
      if (lat >= 100) check("w16_timeout", 0, 1);
      check("w16_lat", lat, LAT16);
      check("w16_busy_cycles", busy_cnt, NPP16 + EXTRA);
      check("w16_product", product16, 32'h0001_FFFE);
      check("w16_err", err16, 1'b0);
      @(negedge clk);
      check("w16_done_single", done16, 1'b0);
      check("w16_idle", state16, 3'd0);
      check("w16_pp_idx", pp_idx16, 4'd15);
      check("sb_empty", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mult_seq_digit.md
Name: mult_seq_digit

Overview:
- Parametrised sequential unsigned multiplier: W-bit x W-bit operands, computed one D x D digit partial product per cycle.
- Shifts and accumulates each partial product into a 2W-bit result.
- Next-generation multiplier block: controller and datapath in one unit, with busy/done/err handshake.
- Sits between a host sequencer (start pulse) and downstream logic that consumes product on done.

Parameters:
- W, 8, operand width in bits; must be a multiple of D.
- D, 4, digit width in bits; D >= 1.
- Derived constants:
  - NCH = W/D, digits per operand.
  - NPP = NCH*NCH, partial products per multiply.
  - IW = clog2(NPP), with a minimum of 1.

Ports:
- clk  in  1  clock, rising edge.
- reset_a  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request; operands sampled on the same edge.
- a  in  W  multiplicand.
- b  in  W  multiplier.
- product  out  2W  result register; holds its value until the next accepted start.
- done  out  1  one-cycle pulse; product is valid in that cycle.
- busy  out  1  high in CALC (and DRAIN when the optional feature is compiled in).
- err  out  1  high while in ERR.
- state_out  out  3  current state encoding, for debug.
- pp_idx  out  IW  index of the partial product being accumulated.

Behaviour:
- Reset (reset_a low, asynchronous):
  - state = IDLE.
  - product, pp_idx, internal operand registers = 0.
  - done = busy = err = 0.
- State encoding: IDLE=0, CALC=1, DRAIN=2, DONE=3, ERR=4. Any other code -> IDLE on the next edge.
- IDLE:
  - start=1: latch a and b, clear the accumulator, pp_idx=0 -> CALC.
  - start=0: stay in IDLE.
- CALC, each cycle with k = pp_idx, i = k mod NCH, j = k div NCH:
  - accumulator += (a_dig[i] * b_dig[j]) << ((i+j)*D).
  - Accumulation is 2W bits wide; it never overflows, because the full product fits in 2W bits.
  - k == NPP-1 -> DONE (or DRAIN with the optional feature); otherwise pp_idx++.
  - start=1 during CALC -> abort to ERR. The accumulation in that cycle is discarded; product is unchanged.
- DONE:
  - done=1 for exactly one cycle; product <= accumulator on entry, so it is visible in the DONE cycle.
  - start=0 -> IDLE.
  - start=1 -> accepted as a new request: latch operands -> CALC. Back-to-back operation carries no bubble.
- ERR:
  - err=1, busy=0, done=0.
  - Stays in ERR while start=0.
  - start=1 -> latch operands -> CALC (restart).
- Latency:
  - Edge sampling start to the cycle done is high = NPP+1 cycles.
  - Default W=8, D=4: 5 cycles.
- pp_idx wraps to 0 on every accepted start; it is never observed beyond NPP-1.
- Reset mid-operation: immediate return to IDLE. No done pulse. product is cleared.

Optional Feature:
- Macro: MULT_SEQ_PIPE_EN.
- Defined:
  - A register is inserted between the digit multiplier/shifter and the accumulator.
  - CALC exits to DRAIN, where the final partial product is accumulated, then DONE.
  - Latency becomes NPP+2; busy is also high in DRAIN.
  - start in DRAIN -> ERR.
- Undefined:
  - No pipeline register; the DRAIN state is unreachable.
  - Latency is NPP+1.

Decomposition:
- Package mult_seq_pkg holds:
  - the state localparams (IDLE, CALC, DRAIN, DONE, ERR) and the 3-bit state width;
  - a function computing IW from W and D.
- Sub-module mult_seq_digit_mul: combinational D x D unsigned multiplier producing a 2D-bit result, instantiated once.
- Digit select, shift and accumulate logic stays in the parent.

Test Plan:
- W=8, D=4, a=0x12, b=0x34, start pulse at cycle 0 -> busy high cycles 1-4, pp_idx 0..3, done high at cycle 5 only, product=0x03A8.
- W=8, D=4, a=0xFF, b=0xFF -> product=0xFE01. Repeat with a=0x00, b=0xAB -> product=0x0000. In both, done is a single-cycle pulse.
- Back-to-back: start=1 in the DONE cycle with a=0x0F, b=0x10 -> no IDLE cycle, next done 5 cycles later, product=0x00F0.
- start=1 at cycle 2 of CALC -> ERR, err=1, product keeps its prior value. Then start pulse with a=0x03, b=0x05 -> err clears, product=0x000F, done pulses.
- reset_a low asynchronously mid-CALC -> state_out=0, product=0, busy=0 within the same cycle. No done pulse after release.
- W=16, D=4, a=0xFFFF, b=0x0002 -> 16 CALC cycles, product=0x0001FFFE. With MULT_SEQ_PIPE_EN: done one cycle later, same value.
